// File: rtl/wb_gain_apply.sv
// wb_gain_apply
//   Auto-white-balance applier. Takes per-frame R/G/B means from the
//   statistics block, computes R and B gains relative to G with a
//   sequential restoring divider, and applies the active gains to the pixel
//   stream. New gains are committed only at frame boundaries so no frame is
//   processed with a mix of old and new gains.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   stats_valid_i     one-cycle pulse, r/g/b_mean_i valid
//   r/g/b_mean_i      frame means
//   valid_i, color_i, value_i, last_i   input pixel stream (0=R 1=G 2=B 3=rsvd)
//   valid_o, color_o, value_o, last_o   corrected pixel stream, latency 2
//   busy_o            gain computation or commit pending
//   r_gain_o, b_gain_o  active gains, unsigned Q(GAIN_W-FRAC_W).FRAC_W
//
// Handshake: no backpressure. A pixel is transferred on every cycle with
// valid_i high; last_i is meaningful only with valid_i. valid_o follows
// valid_i exactly two cycles later, and last_o is only ever high with valid_o.

module wb_gain_apply #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 6,
  parameter int GAIN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stats_valid_i,
  input  logic [DATA_W-1:0] r_mean_i,
  input  logic [DATA_W-1:0] g_mean_i,
  input  logic [DATA_W-1:0] b_mean_i,
  input  logic              valid_i,
  input  logic [1:0]        color_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic              last_i,
  output logic              valid_o,
  output logic [1:0]        color_o,
  output logic [DATA_W-1:0] value_o,
  output logic              last_o,
  output logic              busy_o,
  output logic [GAIN_W-1:0] r_gain_o,
  output logic [GAIN_W-1:0] b_gain_o
);

  localparam int NUM_W  = DATA_W + FRAC_W;
  localparam int CNT_W  = $clog2(NUM_W);
  localparam int PROD_W = DATA_W + GAIN_W;

  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
  localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1 << FRAC_W);
  localparam logic [PROD_W:0]   ROUND_C  = (PROD_W+1)'(1 << (FRAC_W-1));
  localparam logic [PROD_W:0]   PIX_MAX  = (PROD_W+1)'((1 << DATA_W) - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DIV_R       = 2'd1,
    DIV_B       = 2'd2,
    WAIT_COMMIT = 2'd3
  } state_t;

  state_t              state;

  logic [DATA_W-1:0]   r_mean_q;
  logic [DATA_W-1:0]   g_mean_q;
  logic [DATA_W-1:0]   b_mean_q;
  logic [DATA_W:0]     div_rem;
  logic [NUM_W-1:0]    div_q;     // numerator shifts out of the top, quotient in at the bottom
  logic [CNT_W-1:0]    div_cnt;
  logic [GAIN_W-1:0]   r_shadow;
  logic [GAIN_W-1:0]   b_shadow;
  logic                frame_active;

  // ---------------------------------------------------------------------
  // One restoring-division step
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0]   divisor;
  logic [DATA_W:0]     rem_shift;
  logic                q_bit;
  logic [DATA_W:0]     rem_next;
  logic [NUM_W-1:0]    q_next;
  logic [GAIN_W-1:0]   div_result;

  always_comb begin
    divisor    = (state == DIV_B) ? b_mean_q : r_mean_q;
    rem_shift  = {div_rem[DATA_W-1:0], div_q[NUM_W-1]};
    q_bit      = (rem_shift >= {1'b0, divisor});
    rem_next   = q_bit ? (rem_shift - {1'b0, divisor}) : rem_shift;
    q_next     = {div_q[NUM_W-2:0], q_bit};
    // A zero divisor sets every quotient bit, so it saturates to GAIN_MAX
    // through the same clamp as any other oversized quotient.
    div_result = (q_next > NUM_W'(GAIN_MAX)) ? GAIN_MAX : q_next[GAIN_W-1:0];
  end

  // ---------------------------------------------------------------------
  // Gain FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r_mean_q <= '0;
      g_mean_q <= '0;
      b_mean_q <= '0;
      div_rem  <= '0;
      div_q    <= '0;
      div_cnt  <= '0;
      r_shadow <= GAIN_ONE;
      b_shadow <= GAIN_ONE;
      r_gain_o <= GAIN_ONE;
      b_gain_o <= GAIN_ONE;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stats_valid_i) begin
            r_mean_q <= r_mean_i;
            g_mean_q <= g_mean_i;
            b_mean_q <= b_mean_i;
            div_rem  <= '0;
            div_q    <= {g_mean_i, {FRAC_W{1'b0}}};
            div_cnt  <= '0;
            state    <= DIV_R;
            busy_o   <= 1'b1;
          end
        end
        DIV_R, DIV_B: begin
          div_rem <= rem_next;
          div_q   <= q_next;
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == CNT_W'(NUM_W-1)) begin
            div_cnt <= '0;
            if (state == DIV_R) begin
              r_shadow <= div_result;
              // Reload the numerator for the blue division.
              div_rem  <= '0;
              div_q    <= {g_mean_q, {FRAC_W{1'b0}}};
              state    <= DIV_B;
            end else begin
              b_shadow <= div_result;
              state    <= WAIT_COMMIT;
            end
          end
        end
        WAIT_COMMIT: begin
          // Commit between frames, or on the edge that takes the last pixel
          // (that pixel samples the old gains on this same edge).
          if (!frame_active || (valid_i && last_i)) begin
            r_gain_o <= r_shadow;
            b_gain_o <= b_shadow;
            state    <= IDLE;
            busy_o   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_active <= 1'b0;
    end else if (valid_i) begin
      frame_active <= !last_i;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------
  logic              s1_valid;
  logic              s1_last;
  logic [1:0]        s1_color;
  logic [DATA_W-1:0] s1_value;
  logic [GAIN_W-1:0] s1_gain;
  logic              s1_bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_color  <= '0;
      s1_value  <= '0;
      s1_gain   <= '0;
      s1_bypass <= 1'b0;
    end else begin
      s1_valid <= valid_i;
      s1_last  <= valid_i & last_i;
      if (valid_i) begin
        s1_color  <= color_i;
        s1_value  <= value_i;
        s1_gain   <= (color_i == 2'd0) ? r_gain_o : b_gain_o;
        s1_bypass <= (color_i == 2'd1) || (color_i == 2'd3);
      end
    end
  end

  logic [PROD_W-1:0] product;
  logic [PROD_W:0]   rounded;
  logic [PROD_W:0]   shifted;
  logic [DATA_W-1:0] corrected;

  always_comb begin
    product   = PROD_W'(s1_value) * PROD_W'(s1_gain);
    rounded   = {1'b0, product} + ROUND_C;
    shifted   = rounded >> FRAC_W;
    corrected = (shifted > PIX_MAX) ? '1 : shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      color_o <= '0;
      value_o <= '0;
    end else begin
      valid_o <= s1_valid;
      last_o  <= s1_valid & s1_last;
      if (s1_valid) begin
        color_o <= s1_color;
        value_o <= s1_bypass ? s1_value : corrected;
      end
    end
  end

endmodule

// File: tb/tb_wb_gain_apply.sv
module tb_wb_gain_apply;

  localparam int W = 11;  // {last, color[1:0], value[7:0]}

  logic       clk;
  logic       rst_n;
  logic       stats_valid_i;
  logic [7:0] r_mean_i;
  logic [7:0] g_mean_i;
  logic [7:0] b_mean_i;
  logic       valid_i;
  logic [1:0] color_i;
  logic [7:0] value_i;
  logic       last_i;
  logic       valid_o;
  logic [1:0] color_o;
  logic [7:0] value_o;
  logic       last_o;
  logic       busy_o;
  logic [7:0] r_gain_o;
  logic [7:0] b_gain_o;

  wb_gain_apply dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stats_valid_i (stats_valid_i),
    .r_mean_i      (r_mean_i),
    .g_mean_i      (g_mean_i),
    .b_mean_i      (b_mean_i),
    .valid_i       (valid_i),
    .color_i       (color_i),
    .value_i       (value_i),
    .last_i        (last_i),
    .valid_o       (valid_o),
    .color_o       (color_o),
    .value_o       (value_o),
    .last_o        (last_o),
    .busy_o        (busy_o),
    .r_gain_o      (r_gain_o),
    .b_gain_o      (b_gain_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  int  m_r_gain = 64;
  int  m_b_gain = 64;
  int  m_r_shadow = 64;
  int  m_b_shadow = 64;
  bit  m_pending = 0;
  bit  m_frame_active = 0;

  function automatic int ref_gain(int g, int d);
    int q;
    if (d == 0) return 255;
    q = (g * 64) / d;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic int ref_pix(int c, int v, int rg, int bg);
    int gain;
    int r;
    if (c == 0) gain = rg;
    else if (c == 2) gain = bg;
    else return v;
    r = (v * gain + 32) / 64;
    return (r > 255) ? 255 : r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o) begin
        logic [W-1:0] e;
        int ec;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pixel: got value=%0d color=%0d last=%0d, required none", value_o, color_o, last_o);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if ({last_o, color_o, value_o} !== e || ec != cyc)
            $display("FAIL pixel_out: got last=%0d color=%0d value=%0d cyc=%0d, required last=%0d color=%0d value=%0d cyc=%0d",
                     last_o, color_o, value_o, cyc, e[10], e[9:8], e[7:0], ec);
          else
            n_pass++;
        end
      end else begin
        if (last_o) begin
          n_checks++;
          $display("FAIL last_without_valid: got last_o=1, required 0");
        end
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
          n_checks++;
          $display("FAIL missing_pixel: got valid_o=0 at cyc %0d, required pixel value=%0d", cyc, exp_q[0][7:0]);
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks (called just after a negedge) ----------------
  task automatic drive_pixel(input int c, input int v, input bit l);
    int ev;
    valid_i = 1'b1;
    color_i = 2'(c);
    value_i = 8'(v);
    last_i  = l;
    ev = ref_pix(c, v, m_r_gain, m_b_gain);
    exp_q.push_back({l, 2'(c), 8'(ev)});
    exp_cyc_q.push_back(cyc + 2);
    if (l && m_pending) begin
      m_r_gain = m_r_shadow;
      m_b_gain = m_b_shadow;
      m_pending = 0;
    end
    m_frame_active = !l;
    @(negedge clk);
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_stats(input int r, input int g, input int b);
    stats_valid_i = 1'b1;
    r_mean_i = 8'(r);
    g_mean_i = 8'(g);
    b_mean_i = 8'(b);
    m_r_shadow = ref_gain(g, r);
    m_b_shadow = ref_gain(g, b);
    m_pending  = 1;
    @(negedge clk);
    stats_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 200) $display("FAIL busy_timeout: got busy_o=1 after %0d cycles, required 0", n);
    else n_pass++;
    if (m_pending && !m_frame_active) begin
      m_r_gain = m_r_shadow;
      m_b_gain = m_b_shadow;
      m_pending = 0;
    end
  endtask

  task automatic check_gains(input string tag);
    n_checks++;
    if (r_gain_o !== 8'(m_r_gain) || b_gain_o !== 8'(m_b_gain))
      $display("FAIL gains_%s: got r=%0d b=%0d, required r=%0d b=%0d", tag, r_gain_o, b_gain_o, m_r_gain, m_b_gain);
    else n_pass++;
  endtask

  task automatic drain();
    idle(4);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d pending pixels, required 0", exp_q.size());
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if (valid_o !== 1'b0 || last_o !== 1'b0 || color_o !== 2'd0 || value_o !== 8'd0)
      $display("FAIL reset_pixel: got v=%0d l=%0d c=%0d val=%0d, required all 0", valid_o, last_o, color_o, value_o);
    else n_pass++;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy: got %0d, required 0", busy_o);
    else n_pass++;
    check_gains("reset");
  endtask

  task automatic test_unity_passthrough();
    drive_pixel(0, 100, 0);
    drive_pixel(1, 100, 0);
    drive_pixel(2, 100, 1);
    drain();
    check_gains("unity");
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL unity_busy: got %0d, required 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_gain_compute();
    int n = 0;
    send_stats(64, 128, 32);
    while (busy_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n != 29) $display("FAIL busy_length: got %0d cycles, required 29", n);
    else n_pass++;
    m_r_gain = m_r_shadow;
    m_b_gain = m_b_shadow;
    m_pending = 0;
    n_checks++;
    if (r_gain_o !== 8'd128 || b_gain_o !== 8'd255)
      $display("FAIL gain_compute: got r=%0d b=%0d, required r=128 b=255", r_gain_o, b_gain_o);
    else n_pass++;
    drive_pixel(0, 100, 0);   // 200
    drive_pixel(2, 40, 0);    // 159
    drive_pixel(2, 100, 0);   // 255 clamp
    drive_pixel(1, 77, 1);    // 77
    drain();
  endtask

  task automatic test_midframe_commit();
    int old_r;
    int old_b;
    old_r = m_r_gain;
    old_b = m_b_gain;
    drive_pixel(0, 90, 0);
    send_stats(100, 50, 25);   // r=32, b=128
    idle(40);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL midframe_busy: got %0d, required 1", busy_o);
    else n_pass++;
    n_checks++;
    if (r_gain_o !== 8'(old_r) || b_gain_o !== 8'(old_b))
      $display("FAIL midframe_hold: got r=%0d b=%0d, required r=%0d b=%0d", r_gain_o, b_gain_o, old_r, old_b);
    else n_pass++;
    drive_pixel(2, 60, 0);
    drive_pixel(0, 120, 1);     // still old gains
    check_gains("midframe_commit");
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL midframe_busy_clear: got %0d, required 0", busy_o);
    else n_pass++;
    drive_pixel(0, 120, 0);     // new gains
    drive_pixel(2, 60, 1);
    drain();
  endtask

  task automatic test_div_zero_and_ignore();
    send_stats(0, 50, 50);
    idle(3);
    stats_valid_i = 1'b1;      // ignored: divider already running
    r_mean_i = 8'd10;
    g_mean_i = 8'd200;
    b_mean_i = 8'd10;
    @(negedge clk);
    stats_valid_i = 1'b0;
    wait_idle();
    n_checks++;
    if (r_gain_o !== 8'd255 || b_gain_o !== 8'd64)
      $display("FAIL div_zero: got r=%0d b=%0d, required r=255 b=64", r_gain_o, b_gain_o);
    else n_pass++;
    idle(3);
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL ignored_stats_busy: got %0d, required 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_g_zero();
    send_stats(100, 0, 50);
    wait_idle();
    check_gains("g_zero");
    drive_pixel(0, 200, 0);
    drive_pixel(2, 200, 0);
    drive_pixel(1, 77, 0);
    drive_pixel(3, 200, 1);
    drain();
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      send_stats($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      wait_idle();
      check_gains("random");
      for (int p = 0; p < 12; p++) begin
        drive_pixel($urandom_range(0, 3), $urandom_range(0, 255), p == 11);
        idle($urandom_range(0, 2));
      end
      drain();
    end
  endtask

  task automatic test_reset_mid_div();
    send_stats(80, 160, 40);
    idle(18);                   // divider is in its blue half
    valid_i = 1'b1;
    color_i = 2'd0;
    value_i = 8'd100;
    last_i  = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    m_r_gain = 64;
    m_b_gain = 64;
    m_pending = 0;
    m_frame_active = 0;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || r_gain_o !== 8'd64 || b_gain_o !== 8'd64)
      $display("FAIL reset_mid_div: got valid=%0d busy=%0d r=%0d b=%0d, required 0 0 64 64", valid_o, busy_o, r_gain_o, b_gain_o);
    else n_pass++;
    valid_i = 1'b0;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    drive_pixel(0, 150, 0);
    drive_pixel(2, 33, 0);
    drive_pixel(1, 9, 1);
    drain();
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL post_reset_busy: got %0d, required 0", busy_o);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    stats_valid_i = 1'b0;
    r_mean_i = '0;
    g_mean_i = '0;
    b_mean_i = '0;
    valid_i = 1'b0;
    color_i = '0;
    value_i = '0;
    last_i  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    idle(2);
    test_unity_passthrough();
    test_gain_compute();
    test_midframe_commit();
    test_div_zero_and_ignore();
    test_g_zero();
    test_random();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
